sysid_checker: RTL
==================

# sysid_checker

Avalon-MM read master that interrogates the system ID responder at boot or on request. On a start pulse it reads the ID word (word address 0) and the timestamp word (word address 1), latches both, and compares them against build-time expected values. It sits next to the HPS bridge in the FPGA fabric and gives firmware and status LEDs a hardware-level "bitstream matches software" flag.

## Interface
- EXPECTED_ID, 32'hACD5_1302, expected value at word address 0.
- EXPECTED_TS, 32'h5925_2B95, expected value at word address 1.
- TIMEOUT_CYCLES, 255, maximum cycles allowed per read from read assertion to readdatavalid; legal range 1..65535.
- clock, in, 1, single clock domain.
- reset, in, 1, asynchronous, active-high.
- start, in, 1, one-cycle request to run a check; honoured only in IDLE.
- busy, out, 1, high from the cycle after accepted start until done.
- done, out, 1, one-cycle pulse when a check completes.
- pass, out, 1, set to 1 if both words match, else 0; held until the next accepted start.
- timeout, out, 1, set to 1 if the last check aborted on timeout; held until the next accepted start.
- id_value, out, 32, captured ID word.
- ts_value, out, 32, captured timestamp word.
- avm_address, out, 1, word address.
- avm_read, out, 1, read request.
- avm_waitrequest, in, 1, stalls the request.
- avm_readdata, in, 32, read data.
- avm_readdatavalid, in, 1, qualifies avm_readdata.

## Operation
- FSM states: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CMP.
- IDLE: on start go to RD_ID. In the same edge, clear pass, timeout, id_value and ts_value.
- RD_ID: avm_read=1, avm_address=0. When avm_waitrequest=0, go to WAIT_ID.
- WAIT_ID: on avm_readdatavalid, capture id_value and go to RD_TS.
- RD_TS and WAIT_TS: same sequence with address 1, capturing ts_value.
- CMP: for one cycle, pass <= (id_value==EXPECTED_ID) && (ts_value==EXPECTED_TS). Assert done and return to IDLE.
- Only one read is outstanding at a time.
- avm_readdatavalid is ignored outside the WAIT states. A stray beat is dropped.
- start while busy is ignored, with no queuing.
- avm_read and avm_address are registered outputs. Address and read stay stable while waitrequest is high.
- Reset: state=IDLE. All outputs 0, including avm_read, avm_address, busy, done, pass, timeout, id_value and ts_value.
- Reset mid-transaction drops avm_read immediately. Any late readdatavalid is ignored.

## Timing
- start sampled at edge 0. avm_read is high during cycle 1.
- With zero waitrequest and read latency 1:
  - ID data is valid in cycle 2.
  - avm_read for the timestamp is high in cycle 3.
  - Timestamp data is valid in cycle 4.
  - done is high in cycle 5.
- Each waitrequest cycle or extra latency cycle adds exactly one cycle.
- busy rises in cycle 1 and falls in the same cycle as done (cycle 5 minimum).
- pass, timeout and the captured values are valid from the done cycle onward.

## Configuration
- Macro SYSID_CHECKER_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to RD_ID and RD_TS and increments each cycle in the RD and WAIT states.
  - When the count reaches TIMEOUT_CYCLES, the block deasserts avm_read, sets timeout=1 and pass=0, pulses done next cycle, and returns to IDLE.
  - Data captured on the same cycle as expiry wins: no timeout is flagged.
- Not defined: no counter; the block waits indefinitely, and timeout is tied to 0.

## Structure
- Package sysid_checker_pkg holds:
  - the state enum;
  - ADDR_ID=1'b0 and ADDR_TS=1'b1;
  - the default expected constants.
- One natural sub-module: sysid_checker_timeout, the counter with clear, enable and expired outputs, instantiated only under the macro.

## Test plan
- Responder with zero wait and latency 1 returns ACD51302 and 59252B95 → done in cycle 5, pass=1, timeout=0, id_value and ts_value match.
- Responder returns 59252B94 for the timestamp → done, pass=0, ts_value=59252B94.
- 3 waitrequest cycles on each read plus latency 2 → avm_address and avm_read stay stable while stalled; done in cycle 13; pass=1.
- start pulsed again in cycles 2 and 4 → ignored; exactly one done pulse and two reads.
- With the macro and TIMEOUT_CYCLES=10, the responder never asserts readdatavalid → timeout=1, pass=0, done once, avm_read low afterward. Without the macro → busy stays high.
- reset asserted in WAIT_TS, then a late readdatavalid → all outputs 0. A following start runs a clean check with pass=1.

Source files
------------

// File: rtl/sysid_checker_pkg.sv
// sysid_checker_pkg: shared types and constants for the system ID checker.
// States of the read/compare sequence, Avalon word addresses of the two ID
// registers and the default build-time expected values.
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ID   = 3'd1,
        WAIT_ID = 3'd2,
        RD_TS   = 3'd3,
        WAIT_TS = 3'd4,
        CMP     = 3'd5
    } state_t;

    localparam logic        ADDR_ID         = 1'b0;
    localparam logic        ADDR_TS         = 1'b1;
    localparam logic [31:0] DEF_EXPECTED_ID = 32'hACD5_1302;
    localparam logic [31:0] DEF_EXPECTED_TS = 32'h5925_2B95;

    // Word comparison used for both the ID and the timestamp check.
    function automatic logic words_match(input logic [31:0] a, input logic [31:0] b);
        return (a == b);
    endfunction

endpackage

// File: rtl/sysid_checker_timeout.sv
// sysid_checker_timeout: per-read watchdog for the system ID checker.
// Only instantiated when SYSID_CHECKER_TIMEOUT_EN is defined. The count is
// cleared on entry to a read phase and advances while a read is in flight;
// expired flags the cycle that is the LIMIT-th cycle of the read.
module sysid_checker_timeout
    import sysid_checker_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] count_r;

    // Cycle counter: clear wins, saturates instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= 16'd0;
        end else if (clear) begin
            count_r <= 16'd0;
        end else if (enable && (count_r != 16'hFFFF)) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r >= LAST);

endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that reads the system ID word
// (address 0) and timestamp word (address 1) on a start pulse, latches both
// and flags whether they equal the build-time expected values.
// Optional per-read watchdog: define SYSID_CHECKER_TIMEOUT_EN.
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("sysid_checker: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t state_r;
    state_t next_state_s;
    logic   cap_id_s;
    logic   cap_ts_s;
    logic   abort_s;
    logic   expired_s;

`ifdef SYSID_CHECKER_TIMEOUT_EN
    logic clear_s;
    logic in_read_s;

    // Restart the watchdog on every fresh read phase.
    assign clear_s   = ((next_state_s == RD_ID) || (next_state_s == RD_TS)) &&
                       (next_state_s != state_r);
    assign in_read_s = (state_r == RD_ID) || (state_r == WAIT_ID) ||
                       (state_r == RD_TS) || (state_r == WAIT_TS);

    sysid_checker_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear_s),
        .enable  (in_read_s),
        .expired (expired_s)
    );
`else
    assign expired_s = 1'b0;
`endif

    // Next-state logic; returned data wins over a watchdog expiry in the same cycle.
    always_comb begin
        next_state_s = state_r;
        cap_id_s     = 1'b0;
        cap_ts_s     = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = RD_ID;
                else       next_state_s = IDLE;
            end
            RD_ID: begin
                if (expired_s) begin
                    next_state_s = CMP;
                    abort_s      = 1'b1;
                end else if (!avm_waitrequest) begin
                    next_state_s = WAIT_ID;
                end else begin
                    next_state_s = RD_ID;
                end
            end
            WAIT_ID: begin
                if (avm_readdatavalid) begin
                    next_state_s = RD_TS;
                    cap_id_s     = 1'b1;
                end else if (expired_s) begin
                    next_state_s = CMP;
                    abort_s      = 1'b1;
                end else begin
                    next_state_s = WAIT_ID;
                end
            end
            RD_TS: begin
                if (expired_s) begin
                    next_state_s = CMP;
                    abort_s      = 1'b1;
                end else if (!avm_waitrequest) begin
                    next_state_s = WAIT_TS;
                end else begin
                    next_state_s = RD_TS;
                end
            end
            WAIT_TS: begin
                if (avm_readdatavalid) begin
                    next_state_s = CMP;
                    cap_ts_s     = 1'b1;
                end else if (expired_s) begin
                    next_state_s = CMP;
                    abort_s      = 1'b1;
                end else begin
                    next_state_s = WAIT_TS;
                end
            end
            CMP:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register and registered outputs; bus controls follow the next state
    // so they are already valid in the first cycle of each phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            avm_read    <= 1'b0;
            avm_address <= ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
        end else begin
            state_r     <= next_state_s;
            avm_read    <= (next_state_s == RD_ID) || (next_state_s == RD_TS);
            avm_address <= (next_state_s == RD_TS) ? ADDR_TS : ADDR_ID;
            busy        <= (next_state_s != IDLE) && (next_state_s != CMP);
            done        <= (next_state_s == CMP);
            if ((state_r == IDLE) && start) begin
                pass     <= 1'b0;
                timeout  <= 1'b0;
                id_value <= 32'd0;
                ts_value <= 32'd0;
            end else if (cap_id_s) begin
                id_value <= avm_readdata;
            end else if (cap_ts_s) begin
                ts_value <= avm_readdata;
                pass     <= words_match(id_value, EXPECTED_ID) &&
                            words_match(avm_readdata, EXPECTED_TS);
            end else if (abort_s) begin
                timeout  <= 1'b1;
                pass     <= 1'b0;
            end else begin
                pass     <= pass;
            end
        end
    end

endmodule
